// File: rtl/sensor_input_conditioner.sv
// Sensor/button front end: 2-flop sync, ticked debounce per channel, button press
// pulses and an all-channels-settled flag.
module sensor_input_conditioner #(
    parameter int unsigned SAMPLE_DIV     = 50000,
    parameter int unsigned DEBOUNCE_COUNT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_low_water,
    input  logic raw_mid_water,
    input  logic raw_high_water,
    input  logic raw_earth_humidity,
    input  logic raw_air_humidity,
    input  logic raw_low_temperature,
    input  logic raw_button_3_n,
    input  logic raw_button_2_n,
    output logic low_water_level,
    output logic mid_water_level,
    output logic high_water_level,
    output logic earth_humidity,
    output logic air_humidity,
    output logic low_temperature,
    output logic pulse_3,
    output logic pulse_2,
    output logic sensors_settled
);

    localparam int unsigned NCH = 8;
    localparam int unsigned PW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CW  = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
    localparam int unsigned TW  = $clog2(DEBOUNCE_COUNT + 1);

    logic [NCH-1:0]         raw_s;
    logic [NCH-1:0]         sync1_q;
    logic [NCH-1:0]         sync2_q;
    logic [PW-1:0]          presc_q;
    logic [PW-1:0]          presc_d;
    logic                   tick_s;
    logic [NCH-1:0][CW-1:0] cnt_q;
    logic [NCH-1:0][CW-1:0] cnt_d;
    logic [NCH-1:0]         stable_q;
    logic [NCH-1:0]         stable_d;
    logic [1:0]             btn_prev_q;
    logic [1:0]             pulse_q;
    logic [1:0]             pulse_d;
    logic [TW-1:0]          start_q;
    logic [TW-1:0]          start_d;
    logic                   settled_q;
    logic                   settled_d;
    logic                   all_idle_s;

    // Buttons are inverted here so every channel is active-high and "released" is 0.
    assign raw_s = {~raw_button_2_n, ~raw_button_3_n, raw_low_temperature, raw_air_humidity,
                    raw_earth_humidity, raw_high_water, raw_mid_water, raw_low_water};

    // Prescaler wrap and sample tick generation.
    always_comb begin
        tick_s = (presc_q == PW'(SAMPLE_DIV - 1));
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Per-channel debounce: any agreeing tick discards a partial count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < NCH; i++) begin
            if (!tick_s) begin
                cnt_d[i] = cnt_q[i];
            end else if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_COUNT - 1)) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Startup window, settled flag and button press edge detection.
    always_comb begin
        all_idle_s = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (cnt_q[i] != '0) begin
                all_idle_s = 1'b0;
            end else begin
                all_idle_s = all_idle_s;
            end
        end
        if (tick_s && (start_q != TW'(DEBOUNCE_COUNT))) begin
            start_d = start_q + TW'(1);
        end else begin
            start_d = start_q;
        end
        settled_d = (start_q == TW'(DEBOUNCE_COUNT)) && all_idle_s;
        pulse_d   = stable_q[7:6] & ~btn_prev_q;
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            presc_q    <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            btn_prev_q <= 2'b00;
            pulse_q    <= 2'b00;
            start_q    <= '0;
            settled_q  <= 1'b0;
        end else begin
            sync1_q    <= raw_s;
            sync2_q    <= sync1_q;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            btn_prev_q <= stable_q[7:6];
            pulse_q    <= pulse_d;
            start_q    <= start_d;
            settled_q  <= settled_d;
        end
    end

    assign low_water_level  = stable_q[0];
    assign mid_water_level  = stable_q[1];
    assign high_water_level = stable_q[2];
    assign earth_humidity   = stable_q[3];
    assign air_humidity     = stable_q[4];
    assign low_temperature  = stable_q[5];
    assign pulse_3          = pulse_q[0];
    assign pulse_2          = pulse_q[1];
    assign sensors_settled  = settled_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Bench for sensor_input_conditioner: hand-derived vector table plus random
// stimulus against a tick-level reference model.
module tb_sensor_input_conditioner;

    localparam int SD = 4;
    localparam int DC = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic raw_low_water = 1'b0, raw_mid_water = 1'b0, raw_high_water = 1'b0;
    logic raw_earth_humidity = 1'b0, raw_air_humidity = 1'b0, raw_low_temperature = 1'b0;
    logic raw_button_3_n = 1'b1, raw_button_2_n = 1'b1;
    logic low_water_level, mid_water_level, high_water_level;
    logic earth_humidity, air_humidity, low_temperature;
    logic pulse_3, pulse_2, sensors_settled;

    sensor_input_conditioner #(.SAMPLE_DIV(SD), .DEBOUNCE_COUNT(DC)) dut (
        .clock(clock), .reset_n(reset_n),
        .raw_low_water(raw_low_water), .raw_mid_water(raw_mid_water),
        .raw_high_water(raw_high_water), .raw_earth_humidity(raw_earth_humidity),
        .raw_air_humidity(raw_air_humidity), .raw_low_temperature(raw_low_temperature),
        .raw_button_3_n(raw_button_3_n), .raw_button_2_n(raw_button_2_n),
        .low_water_level(low_water_level), .mid_water_level(mid_water_level),
        .high_water_level(high_water_level), .earth_humidity(earth_humidity),
        .air_humidity(air_humidity), .low_temperature(low_temperature),
        .pulse_3(pulse_3), .pulse_2(pulse_2), .sensors_settled(sensors_settled)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: channel levels, consecutive-differing-tick runs.
    logic [7:0] m_s1, m_s2, m_lvl, m_lvl_prev;
    int         m_run [8];
    int         m_ticks;
    int         m_cyc;
    logic       m_settled;
    logic [1:0] m_pulse;

    typedef struct {
        bit         rst;
        logic [5:0] sens;
        logic [1:0] btn_n;
        int         hold;
        logic [8:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [8:0] dut_out();
        return {sensors_settled, pulse_2, pulse_3, low_temperature, air_humidity,
                earth_humidity, high_water_level, mid_water_level, low_water_level};
    endfunction

    function automatic logic [8:0] model_out();
        return {m_settled, m_pulse, m_lvl[5:0]};
    endfunction

    function automatic logic [7:0] raw_vec();
        return {~raw_button_2_n, ~raw_button_3_n, raw_low_temperature, raw_air_humidity,
                raw_earth_humidity, raw_high_water, raw_mid_water, raw_low_water};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0;
        foreach (m_run[c]) m_run[c] = 0;
        m_ticks = 0; m_cyc = 0; m_settled = 1'b0; m_pulse = 2'b00;
    endtask

    task automatic model_edge();
        logic [7:0] lvl_old;
        logic [1:0] p_new;
        logic       s_new;
        bit         idle;
        lvl_old = m_lvl;
        p_new   = m_lvl[7:6] & ~m_lvl_prev[7:6];
        idle    = 1'b1;
        foreach (m_run[c]) if (m_run[c] != 0) idle = 1'b0;
        s_new = (m_ticks == DC) && idle;
        if ((m_cyc % SD) == SD - 1) begin
            for (int c = 0; c < 8; c++) begin
                if (m_s2[c] != m_lvl[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == DC) begin
                        m_lvl[c] = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            if (m_ticks < DC) m_ticks = m_ticks + 1;
        end
        m_lvl_prev = lvl_old;
        m_s2       = m_s1;
        m_s1       = raw_vec();
        m_cyc      = m_cyc + 1;
        m_pulse    = p_new;
        m_settled  = s_new;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("model_cycle", dut_out(), model_out());
    endtask

    task automatic apply(input logic [5:0] sens, input logic [1:0] btn_n);
        {raw_low_temperature, raw_air_humidity, raw_earth_humidity,
         raw_high_water, raw_mid_water, raw_low_water} = sens;
        {raw_button_2_n, raw_button_3_n} = btn_n;
    endtask

    task automatic do_reset(input string name, input logic [8:0] exp);
        reset_n = 1'b0;
        model_reset();
        #1;
        check(name, dut_out(), exp);
        repeat (2) @(negedge clock);
        check({name, "_held"}, dut_out(), 9'h000);
        reset_n = 1'b1;
    endtask

    task automatic add(input bit rst, input logic [5:0] s, input logic [1:0] b,
                       input int hold, input logic [8:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.sens = s; v.btn_n = b; v.hold = hold; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] r;
        // Output vector: {settled, pulse_2, pulse_3, temp, air, earth, high, mid, low}
        add(1, 6'h00, 2'b11,  0, 9'h000, "rst_initial");
        add(0, 6'h00, 2'b11, 12, 9'h000, "startup_wait");
        add(0, 6'h00, 2'b11,  1, 9'h100, "settled_rise");
        add(0, 6'h01, 2'b11,  4, 9'h000, "low_first_tick");
        add(0, 6'h01, 2'b11,  6, 9'h000, "low_not_before");
        add(0, 6'h01, 2'b11,  1, 9'h001, "low_accept");
        add(0, 6'h01, 2'b11,  1, 9'h101, "low_settled");
        add(0, 6'h03, 2'b11,  7, 9'h001, "mid_glitch");
        add(0, 6'h01, 2'b11,  4, 9'h001, "mid_reject");
        add(0, 6'h01, 2'b11,  1, 9'h101, "mid_settled");
        add(0, 6'h01, 2'b10, 11, 9'h001, "b3_pre");
        add(0, 6'h01, 2'b10,  1, 9'h141, "b3_pulse");
        add(0, 6'h01, 2'b10,  1, 9'h101, "b3_single");
        add(0, 6'h01, 2'b10, 68, 9'h101, "b3_held");
        add(0, 6'h01, 2'b11, 14, 9'h001, "b3_release");
        add(0, 6'h01, 2'b11,  1, 9'h101, "b3_rel_settled");
        add(0, 6'h01, 2'b10, 11, 9'h001, "b3_pre2");
        add(0, 6'h01, 2'b10,  1, 9'h141, "b3_pulse2");
        add(0, 6'h01, 2'b10,  1, 9'h101, "b3_single2");
        add(0, 6'h0F, 2'b10, 10, 9'h001, "three_at_c2");
        add(1, 6'h0F, 2'b10,  0, 9'h000, "rst_mid_count");
        add(0, 6'h0F, 2'b10, 11, 9'h000, "restart_wait");
        add(0, 6'h0F, 2'b10,  1, 9'h00F, "restart_accept");
        add(0, 6'h0F, 2'b10,  1, 9'h14F, "restart_pulse");
        add(0, 6'h0F, 2'b11, 12, 9'h10F, "b3_release3");
        add(0, 6'h30, 2'b00, 10, 9'h00F, "all_pre");
        add(0, 6'h30, 2'b00,  1, 9'h030, "all_accept");
        add(0, 6'h30, 2'b00,  1, 9'h1F0, "all_pulses");
        add(0, 6'h30, 2'b00,  1, 9'h130, "all_after");

        model_reset();
        #2;
        foreach (vecs[i]) begin
            apply(vecs[i].sens, vecs[i].btn_n);
            if (vecs[i].rst) begin
                do_reset(vecs[i].name, vecs[i].exp);
            end else begin
                repeat (vecs[i].hold) step();
                check(vecs[i].name, dut_out(), vecs[i].exp);
            end
        end

        // Random phase: rare toggles so some changes are accepted, others rejected.
        @(posedge clock);
        #1;
        do_reset("rst_random", 9'h000);
        r = 8'hC0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(0, 19) == 0) r[c] = ~r[c];
            end
            apply(r[5:0], r[7:6]);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
